// File: rtl/lcd_value_display_if.sv
// rtl/lcd_value_display_if.sv - value request handshake bundle for lcd_value_display
interface lcd_value_display_if #(
  parameter int DATA_W = 18
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_line;
  logic              in_hex;

  modport master (output in_valid, in_data, in_line, in_hex, input in_ready);
  modport slave  (input in_valid, in_data, in_line, in_hex, output in_ready);
endinterface

// File: rtl/lcd_value_display.sv
// rtl/lcd_value_display.sv - HD44780 2x16 value display engine (binary/hex ASCII, timed E strobe)
// Optional LCD_PREFIX_EN: emits "0x"/"0b" ahead of the digits.
module lcd_value_display #(
  parameter int DATA_W        = 18,
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 25,
  parameter int CMD_WAIT_CYC  = 2500,
  parameter int CLR_WAIT_CYC  = 82000,
  parameter int INIT_WAIT_CYC = 750000
) (
  input  logic               clk,
  input  logic               rst,
  lcd_value_display_if.slave req,
  output logic [7:0]         lcd_data,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_en,
  output logic               busy,
  output logic               done
);

  function automatic int maxI(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int atLeast1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  localparam int MAX_WAIT = maxI(maxI(maxI(SETUP_CYC, EN_CYC), maxI(CMD_WAIT_CYC, CLR_WAIT_CYC)),
                                 maxI(INIT_WAIT_CYC, 2));
  localparam int CNT_W = $clog2(MAX_WAIT) + 1;
  localparam int HEX_N = (DATA_W + 3) / 4;
`ifdef LCD_PREFIX_EN
  localparam int PRE_N = 2;
`else
  localparam int PRE_N = 0;
`endif

  // Limits are last-count values, so a zero-cycle request still spends one cycle.
  localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'(atLeast1(SETUP_CYC) - 1);
  localparam logic [CNT_W-1:0] EN_LIM    = CNT_W'(atLeast1(EN_CYC) - 1);
  localparam logic [CNT_W-1:0] CMD_LIM   = CNT_W'(atLeast1(CMD_WAIT_CYC) - 1);
  localparam logic [CNT_W-1:0] CLR_LIM   = CNT_W'(atLeast1(CLR_WAIT_CYC) - 1);
  localparam logic [CNT_W-1:0] INIT_LIM  = CNT_W'(atLeast1(INIT_WAIT_CYC) - 1);

  typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_ADDR, S_CHAR, S_WRAP, S_DONE} state_t;
  typedef enum logic [1:0] {W_OFF, W_SETUP, W_PULSE, W_WAIT} wph_t;

  state_t            state, stateN;
  wph_t              wph, wphN;
  logic [CNT_W-1:0]  cnt, cntN, waitLim;
  logic [2:0]        initIdx, initIdxN;
  logic [5:0]        charIdx, charIdxN;
  logic [DATA_W-1:0] valReg, valN;
  logic              lineReg, lineN, hexReg, hexN;
  logic [7:0]        dataN;
  logic              rsN, enN;
  logic              launch, launchRs, byteDone;
  logic [7:0]        launchByte, initByte, charByte, digitChar;
  logic [5:0]        numChars, pos;
  logic [31:0]       valWide;
  logic [3:0]        digit;

  assign req.in_ready = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign lcd_rw       = 1'b0;

  always_comb begin
    case (initIdx)
      3'd0:    initByte = 8'h38;
      3'd1:    initByte = 8'h0C;
      3'd2:    initByte = 8'h06;
      default: initByte = 8'h01;
    endcase
  end

  // charIdx is the index of the next character to launch; pos counts digits from the LS end.
  assign numChars  = hexReg ? 6'(HEX_N + PRE_N) : 6'(DATA_W + PRE_N);
  assign pos       = numChars - 6'd1 - charIdx;
  assign valWide   = 32'(valReg);
  assign digit     = hexReg ? 4'(valWide >> {pos, 2'b00}) : {3'b000, valWide[pos[4:0]]};
  assign digitChar = (digit < 4'd10) ? (8'h30 + {4'h0, digit}) : (8'h37 + {4'h0, digit});

  always_comb begin
    charByte = digitChar;
`ifdef LCD_PREFIX_EN
    if (charIdx == 6'd0)      charByte = 8'h30;
    else if (charIdx == 6'd1) charByte = hexReg ? 8'h78 : 8'h62;
`endif
  end

  // Clear and home need the long wait; the held byte tells which one is in flight.
  assign waitLim = (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02)) ? CLR_LIM : CMD_LIM;

  always_comb begin
    stateN     = state;
    wphN       = wph;
    cntN       = cnt;
    initIdxN   = initIdx;
    charIdxN   = charIdx;
    valN       = valReg;
    lineN      = lineReg;
    hexN       = hexReg;
    dataN      = lcd_data;
    rsN        = lcd_rs;
    enN        = lcd_en;
    launch     = 1'b0;
    launchByte = 8'h00;
    launchRs   = 1'b0;
    byteDone   = 1'b0;

    case (wph)
      W_SETUP: if (cnt == SETUP_LIM) begin wphN = W_PULSE; enN = 1'b1; cntN = '0; end
               else cntN = cnt + 1'b1;
      W_PULSE: if (cnt == EN_LIM) begin wphN = W_WAIT; enN = 1'b0; cntN = '0; end
               else cntN = cnt + 1'b1;
      W_WAIT:  if (cnt == waitLim) begin wphN = W_OFF; cntN = '0; byteDone = 1'b1; end
               else cntN = cnt + 1'b1;
      default: ;
    endcase

    case (state)
      S_PWR: begin
        if (cnt == INIT_LIM) begin
          launch     = 1'b1;
          launchByte = initByte;
          initIdxN   = initIdx + 3'd1;
          stateN     = S_INIT;
        end else begin
          cntN = cnt + 1'b1;
        end
      end
      S_INIT: if (byteDone) begin
        if (initIdx == 3'd4) stateN = S_IDLE;
        else begin
          launch     = 1'b1;
          launchByte = initByte;
          initIdxN   = initIdx + 3'd1;
        end
      end
      S_IDLE: if (req.in_valid) begin
        valN       = req.in_data;
        lineN      = req.in_line;
        hexN       = req.in_hex;
        charIdxN   = 6'd0;
        launch     = 1'b1;
        launchByte = req.in_line ? 8'hC0 : 8'h80;
        stateN     = S_ADDR;
      end
      S_ADDR, S_WRAP: if (byteDone) begin
        launch     = 1'b1;
        launchRs   = 1'b1;
        launchByte = charByte;
        charIdxN   = charIdx + 6'd1;
        stateN     = S_CHAR;
      end
      S_CHAR: if (byteDone) begin
        if (charIdx == numChars) stateN = S_DONE;
        else if (charIdx == 6'd16) begin
          launch     = 1'b1;
          launchByte = lineReg ? 8'h80 : 8'hC0;
          stateN     = S_WRAP;
        end else begin
          launch     = 1'b1;
          launchRs   = 1'b1;
          launchByte = charByte;
          charIdxN   = charIdx + 6'd1;
        end
      end
      S_DONE:  stateN = S_IDLE;
      default: stateN = S_PWR;
    endcase

    // Bus lines only ever change here, at the start of a setup phase.
    if (launch) begin
      dataN = launchByte;
      rsN   = launchRs;
      wphN  = W_SETUP;
      cntN  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_PWR;
      wph      <= W_OFF;
      cnt      <= '0;
      initIdx  <= 3'd0;
      charIdx  <= 6'd0;
      valReg   <= '0;
      lineReg  <= 1'b0;
      hexReg   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
    end else begin
      state    <= stateN;
      wph      <= wphN;
      cnt      <= cntN;
      initIdx  <= initIdxN;
      charIdx  <= charIdxN;
      valReg   <= valN;
      lineReg  <= lineN;
      hexReg   <= hexN;
      lcd_data <= dataN;
      lcd_rs   <= rsN;
      lcd_en   <= enN;
    end
  end

endmodule
